wb_regfile: RTL and testbench

- Write-back stage of the 5-stage pipelined MIPS core.
- Sits directly downstream of the MEM/WB pipeline register and consumes its W_* outputs.
- Selects the write-back data, suppresses writes from overflowing instructions and commits the result into the 32x32 general register file.
- Provides the two combinational read ports used by the decode stage, with same-cycle write bypass, plus retire and overflow statistics counters.

---
 rtl/wb_regfile_if.sv | 43 ++++
 rtl/wb_regfile.sv | 76 +++++++
 tb/tb_wb_regfile.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// Bundle between the MEM/WB register / decode stage and the write-back register file.
// The slave side is the register file; the optional trace outputs exist only with WB_TRACE_EN.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32,
  parameter int OVF_W  = 16
);
  logic [DATA_W-1:0] W_Dout;
  logic [DATA_W-1:0] W_ALUout;
  logic [4:0]        W_Rw;
  logic              W_MemtoReg;
  logic              W_RegWr;
  logic              W_Overflow;
  logic [4:0]        Ra;
  logic [4:0]        Rb;
  logic [DATA_W-1:0] busA;
  logic [DATA_W-1:0] busB;
  logic [DATA_W-1:0] busW;
  logic              WrEff;
  logic [CNT_W-1:0]  RetireCnt;
  logic [OVF_W-1:0]  OvfCnt;
`ifdef WB_TRACE_EN
  logic              T_Valid;
  logic [4:0]        T_Rw;
  logic [DATA_W-1:0] T_Data;
`endif

  modport master (
    output W_Dout, W_ALUout, W_Rw, W_MemtoReg, W_RegWr, W_Overflow, Ra, Rb,
`ifdef WB_TRACE_EN
    input  T_Valid, T_Rw, T_Data,
`endif
    input  busA, busB, busW, WrEff, RetireCnt, OvfCnt
  );

  modport slave (
    input  W_Dout, W_ALUout, W_Rw, W_MemtoReg, W_RegWr, W_Overflow, Ra, Rb,
`ifdef WB_TRACE_EN
    output T_Valid, T_Rw, T_Data,
`endif
    output busA, busB, busW, WrEff, RetireCnt, OvfCnt
  );
endinterface

// File: rtl/wb_regfile.sv
// MIPS write-back stage: selects busW, commits on the next rising CLK, two combinational bypassed
// read ports, retire/overflow counters; no backpressure. Trace outputs optional via WB_TRACE_EN.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32,
  parameter int OVF_W  = 16
) (
  input logic         CLK,
  input logic         RSTn,
  wb_regfile_if.slave wb
);
  logic [DATA_W-1:0] regs [1:31];
  logic [CNT_W-1:0]  retire_cnt;
  logic [OVF_W-1:0]  ovf_cnt;
  logic [DATA_W-1:0] bus_w;
  logic              wr_eff;
  logic              ovf_evt;

  // W_RegWr=0 forces both enables low even if the rest of the bundle is unknown.
  assign bus_w   = wb.W_MemtoReg ? wb.W_Dout : wb.W_ALUout;
  assign wr_eff  = wb.W_RegWr & ~wb.W_Overflow & (wb.W_Rw != 5'd0);
  assign ovf_evt = wb.W_RegWr & wb.W_Overflow;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
      retire_cnt <= '0;
      ovf_cnt    <= '0;
    end else begin
      if (wr_eff) begin
        regs[wb.W_Rw] <= bus_w;
        retire_cnt    <= retire_cnt + CNT_W'(1);
      end
      if (ovf_evt && (ovf_cnt != {OVF_W{1'b1}})) ovf_cnt <= ovf_cnt + OVF_W'(1);
    end
  end

  // Reads return 0 throughout reset, bypass included.
  always_comb begin
    wb.busA = '0;
    wb.busB = '0;
    if (RSTn && (wb.Ra != 5'd0))
      wb.busA = (wr_eff && (wb.Ra == wb.W_Rw)) ? bus_w : regs[wb.Ra];
    if (RSTn && (wb.Rb != 5'd0))
      wb.busB = (wr_eff && (wb.Rb == wb.W_Rw)) ? bus_w : regs[wb.Rb];
  end

  assign wb.busW      = bus_w;
  assign wb.WrEff     = wr_eff;
  assign wb.RetireCnt = retire_cnt;
  assign wb.OvfCnt    = ovf_cnt;

`ifdef WB_TRACE_EN
  logic              t_valid;
  logic [4:0]        t_rw;
  logic [DATA_W-1:0] t_data;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      t_valid <= 1'b0;
      t_rw    <= '0;
      t_data  <= '0;
    end else begin
      t_valid <= wr_eff;
      if (wr_eff) begin
        t_rw   <= wb.W_Rw;
        t_data <= bus_w;
      end
    end
  end

  assign wb.T_Valid = t_valid;
  assign wb.T_Rw    = t_rw;
  assign wb.T_Data  = t_data;
`endif
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios plus random traffic against a register-array model.
module tb_wb_regfile;
  localparam int DW = 32;
  localparam int CW = 32;
  localparam int OW = 8;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  wb_regfile_if #(.DATA_W(DW), .CNT_W(CW), .OVF_W(OW)) wbi ();
  wb_regfile #(.DATA_W(DW), .CNT_W(CW), .OVF_W(OW)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .wb   (wbi)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] w;
    logic          we;
    logic [CW-1:0] ret;
    logic [OW-1:0] ovf;
    logic          tv;
    logic [4:0]    trw;
    logic [DW-1:0] td;
  } exp_t;

  exp_t          q[$];
  int            total = 0;
  int            bad   = 0;

  logic [DW-1:0] mdl [32];
  logic [CW-1:0] m_ret;
  int            m_ovf;
  logic          m_tv;
  logic [4:0]    m_trw;
  logic [DW-1:0] m_td;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    m_ret = '0;
    m_ovf = 0;
    m_tv  = 1'b0;
    m_trw = '0;
    m_td  = '0;
  endtask

  function automatic logic [DW-1:0] model_read(input logic rstn, input logic [4:0] addr,
                                               input logic we, input logic [4:0] rw,
                                               input logic [DW-1:0] w);
    if (!rstn || addr == 5'd0) return '0;
    if (we && addr == rw) return w;
    return mdl[addr];
  endfunction

  // Drive one MEM/WB bundle on the falling edge, queue the expected outputs, then apply the commit.
  task automatic step(input logic rstn, input logic regwr, input logic mtr, input logic ovf,
                      input logic [4:0] rw, input logic [DW-1:0] alu, input logic [DW-1:0] dout,
                      input logic [4:0] ra, input logic [4:0] rb);
    exp_t e;
    logic we;
    @(negedge CLK);
    RSTn            = rstn;
    wbi.W_RegWr     = regwr;
    wbi.W_MemtoReg  = mtr;
    wbi.W_Overflow  = ovf;
    wbi.W_Rw        = rw;
    wbi.W_ALUout    = alu;
    wbi.W_Dout      = dout;
    wbi.Ra          = ra;
    wbi.Rb          = rb;
    #1;
    if (!rstn) model_reset();
    we    = regwr && !ovf && (rw != 5'd0);
    e.w   = mtr ? dout : alu;
    e.we  = we;
    e.a   = model_read(rstn, ra, we, rw, e.w);
    e.b   = model_read(rstn, rb, we, rw, e.w);
    e.ret = m_ret;
    e.ovf = OW'(m_ovf);
    e.tv  = m_tv;
    e.trw = m_trw;
    e.td  = m_td;
    q.push_back(e);
    if (rstn) begin
      if (we) begin
        mdl[rw] = e.w;
        m_ret   = m_ret + 1;
        m_trw   = rw;
        m_td    = e.w;
      end
      m_tv = we;
      if (regwr && ovf && m_ovf < (1 << OW) - 1) m_ovf = m_ovf + 1;
    end
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: samples two time units before each rising edge and checks against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("busA",      wbi.busA,          e.a);
        chk("busB",      wbi.busB,          e.b);
        chk("busW",      wbi.busW,          e.w);
        chk("WrEff",     DW'(wbi.WrEff),    DW'(e.we));
        chk("RetireCnt", DW'(wbi.RetireCnt), DW'(e.ret));
        chk("OvfCnt",    DW'(wbi.OvfCnt),   DW'(e.ovf));
`ifdef WB_TRACE_EN
        chk("T_Valid",   DW'(wbi.T_Valid),  DW'(e.tv));
        chk("T_Rw",      DW'(wbi.T_Rw),     DW'(e.trw));
        chk("T_Data",    wbi.T_Data,        e.td);
`endif
      end
    end
  end

  initial begin
    logic [DW-1:0] r0, r1;
    wbi.W_RegWr    = 1'b0;
    wbi.W_MemtoReg = 1'b0;
    wbi.W_Overflow = 1'b0;
    wbi.W_Rw       = '0;
    wbi.W_ALUout   = '0;
    wbi.W_Dout     = '0;
    wbi.Ra         = '0;
    wbi.Rb         = '0;
    model_reset();

    // Reset, then read back zeros
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, '0, '0, 5'd5, 5'd31);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, '0, '0, 5'd5, 5'd31);
    // ALU and memory write-back
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'h0000_1234, 32'h0, 5'd8, 5'd9);
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0, 32'hDEAD_BEEF, 5'd8, 5'd9);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, '0, '0, 5'd8, 5'd9);
    // Bypass over an older value
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd10, 32'h11, 32'h0, 5'd0, 5'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd10, 32'h22, 32'h0, 5'd10, 5'd10);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, '0, '0, 5'd10, 5'd10);
    // Overflow suppression and r0 writes
    step(1'b1, 1'b1, 1'b0, 1'b1, 5'd12, 32'h7FFF_FFFF, 32'h0, 5'd12, 5'd10);
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd12);
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 32'h5555_5555, 32'h0, 5'd0, 5'd12);
    // Reset landing on a pending write to r3, then the same write after release
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'hCAFE_0003, 32'h0, 5'd3, 5'd3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'hCAFE_0003, 32'h0, 5'd3, 5'd3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, '0, '0, 5'd3, 5'd8);
    // Drive the overflow counter into saturation
    for (int i = 0; i < (1 << OW) + 3; i++) begin
      r0 = $urandom;
      r1 = $urandom;
      step(1'b1, 1'b1, 1'($urandom), 1'b1, 5'($urandom), r0, r1, 5'($urandom), 5'($urandom));
    end
    // Random traffic including idle bundles with junk fields and occasional resets
    for (int i = 0; i < 400; i++) begin
      r0 = $urandom;
      r1 = $urandom;
      step(($urandom_range(0, 59) != 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 5) == 0), 5'($urandom), r0, r1, 5'($urandom), 5'($urandom));
    end

    repeat (3) @(negedge CLK);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
